// File: rtl/gen_padder_serdes_if.sv
// Frame-in / word-out stream bundle for gen_padder_serdes.
// Latency: none, wires only.
// Backpressure: valid/ready on both the frame side and the word side.
interface gen_padder_serdes_if #(
  parameter int N_CH      = 4,
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 48
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*IN_WIDTH-1:0] in_data;
  logic                     in_sign_ext;
  logic                     in_valid;
  logic                     in_ready;
  logic [OUT_WIDTH-1:0]     out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;

  // Producer of frames and consumer of words.
  modport master (
    output in_data, in_sign_ext, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_last, out_valid
  );

  // The padder/serialiser itself.
  modport slave (
    input  in_data, in_sign_ext, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_last, out_valid
  );
endinterface

// File: rtl/gen_padder_serdes.sv
// Pads each sample of an N_CH frame into an OUT_WIDTH fixed-point word and emits one channel per beat.
// Latency: first word valid 1 cycle after the frame handshake; one word per cycle, gapless between frames.
// Backpressure: out_* held while out_ready is low; in_ready only when idle or on the accepted last beat.
module gen_padder_serdes #(
  parameter int N_CH        = 4,
  parameter int IN_WIDTH    = 12,
  parameter int OUT_WIDTH   = 48,
  parameter int R_PAD_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  gen_padder_serdes_if.slave bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int L_PAD = OUT_WIDTH - IN_WIDTH - R_PAD_WIDTH;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  generate
    if (L_PAD < 0) begin : g_bad_width
      $error("gen_padder_serdes: OUT_WIDTH too small for IN_WIDTH + R_PAD_WIDTH");
    end
    if (N_CH < 1) begin : g_bad_nch
      $error("gen_padder_serdes: N_CH must be at least 1");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [N_CH*IN_WIDTH-1:0] frame_q;
  logic                     sext_q;
  logic                     capture;
  logic                     advance;
  logic [CH_W-1:0]          ch_nx;

  // Sample lands above R_PAD_WIDTH zeros; the bits above it copy the sample MSB only when sign-extending.
  function automatic logic [OUT_WIDTH-1:0] fmt(input logic [IN_WIDTH-1:0] s, input logic sx);
    logic [OUT_WIDTH-1:0] w;
    w = '0;
    w[R_PAD_WIDTH +: IN_WIDTH] = s;
    for (int b = IN_WIDTH + R_PAD_WIDTH; b < OUT_WIDTH; b++) begin
      w[b] = sx & s[IN_WIDTH-1];
    end
    return w;
  endfunction

  assign bus.out_valid = (state_q == SEND);
  assign ch_nx         = bus.out_ch + CH_W'(1);

  // Next state, frame capture / channel advance decisions and the combinational in_ready.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    advance      = 1'b0;
    bus.in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid) begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (bus.out_last) begin
            // Last word leaving: a waiting frame is taken in the same cycle so there is no bubble.
            bus.in_ready = !rst;
            if (bus.in_valid) begin
              capture = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame register and registered output word; the held frame feeds every beat after the first.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q      <= '0;
      sext_q       <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch   <= '0;
      bus.out_last <= 1'b0;
    end else if (capture) begin
      frame_q      <= bus.in_data;
      sext_q       <= bus.in_sign_ext;
      bus.out_data <= fmt(bus.in_data[0 +: IN_WIDTH], bus.in_sign_ext);
      bus.out_ch   <= '0;
      bus.out_last <= (N_CH == 1);
    end else if (advance) begin
      bus.out_data <= fmt(frame_q[int'(ch_nx)*IN_WIDTH +: IN_WIDTH], sext_q);
      bus.out_ch   <= ch_nx;
      bus.out_last <= (ch_nx == LAST_CH);
    end
  end
endmodule

// File: tb/tb_gen_padder_serdes.sv
// Scoreboard bench for gen_padder_serdes: directed frames plus randomized frames and output stalls.
// Latency: expectations queued when a frame is issued, popped by a monitor on every output handshake.
// Backpressure: out_ready driven low in directed stalls and randomly during the random phase.
module tb_gen_padder_serdes;
  localparam int N_CH        = 4;
  localparam int IN_WIDTH    = 12;
  localparam int OUT_WIDTH   = 48;
  localparam int R_PAD_WIDTH = 32;

  typedef struct {
    logic [OUT_WIDTH-1:0] dat;
    int                   ch;
    bit                   last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  beat_t exp_q[$];
  int    beat_cyc[$];

  always #5 clk = ~clk;

  gen_padder_serdes_if #(.N_CH(N_CH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  gen_padder_serdes #(
    .N_CH(N_CH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .R_PAD_WIDTH(R_PAD_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the sample read as signed or unsigned, scaled by 2^R_PAD_WIDTH, taken modulo 2^OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] model(input int unsigned sample, input bit sx);
    longint v;
    v = longint'(sample);
    if (sx && sample >= (1 << (IN_WIDTH - 1))) v = v - (longint'(1) << IN_WIDTH);
    v = v * (longint'(1) << R_PAD_WIDTH);
    return OUT_WIDTH'(v);
  endfunction

  task automatic push_beat(input logic [OUT_WIDTH-1:0] d, input int ch);
    beat_t b;
    b.dat  = d;
    b.ch   = ch;
    b.last = (ch == N_CH - 1);
    exp_q.push_back(b);
  endtask

  task automatic push_frame(input logic [N_CH*IN_WIDTH-1:0] f, input bit sx);
    logic [IN_WIDTH-1:0] s;
    for (int k = 0; k < N_CH; k++) begin
      s = f[k*IN_WIDTH +: IN_WIDTH];
      push_beat(model(int'(s), sx), k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [N_CH*IN_WIDTH-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[N_CH*IN_WIDTH-1:0];
  endfunction

  // Present a frame until accepted; with keep set in_valid stays high for a gapless follow-on frame.
  task automatic send_frame(input logic [N_CH*IN_WIDTH-1:0] f, input bit sx, input bit keep);
    int n;
    bus.in_data     = f;
    bus.in_sign_ext = sx;
    bus.in_valid    = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL in_handshake: in_ready never rose within 200 cycles");
        break;
      end
      tick();
    end
    tick();
    if (!keep) begin
      bus.in_valid    = 1'b0;
      bus.in_data     = rand_frame();
      bus.in_sign_ext = $urandom_range(0, 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every accepted word is compared against the head of the expectation queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got ch %0d data 0x%0h, expected no word", bus.out_ch, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(bus.out_data), 64'(e.dat));
          check("beat_ch", 64'(bus.out_ch), 64'(e.ch));
          check("beat_last", 64'(bus.out_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N_CH*IN_WIDTH-1:0] f;
    logic [N_CH*IN_WIDTH-1:0] g;
    logic [OUT_WIDTH-1:0]     held;
    bit                       sx;
    int                       base;

    // Reset held with in_valid high.
    rst             = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = 48'h123456789ABC;
    bus.in_sign_ext = 1'b1;
    bus.out_ready   = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_ch", 64'(bus.out_ch), 64'd0);
      check("rst_out_last", 64'(bus.out_last), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    tick();

    // Zero-extend frame, literal expectations.
    f = {12'h7FF, 12'h001, 12'h800, 12'hABC};
    push_beat(48'h0ABC00000000, 0);
    push_beat(48'h080000000000, 1);
    push_beat(48'h000100000000, 2);
    push_beat(48'h07FF00000000, 3);
    send_frame(f, 1'b0, 1'b0);
    drain();

    // Same frame sign-extended.
    push_beat(48'hFABC00000000, 0);
    push_beat(48'hF80000000000, 1);
    push_beat(48'h000100000000, 2);
    push_beat(48'h07FF00000000, 3);
    send_frame(f, 1'b1, 1'b0);
    drain();

    // Two frames back to back: eight words on eight consecutive cycles.
    base = beat_cyc.size();
    f = rand_frame();
    g = rand_frame();
    push_frame(f, 1'b1);
    push_frame(g, 1'b0);
    send_frame(f, 1'b1, 1'b1);
    send_frame(g, 1'b0, 1'b0);
    drain();
    check("b2b_beats", 64'(beat_cyc.size() - base), 64'd8);
    if (beat_cyc.size() >= base + 8) begin
      check("b2b_span", 64'(beat_cyc[base+7] - beat_cyc[base]), 64'd7);
    end

    // Stall on ch2 for three cycles while the input bus churns.
    f  = rand_frame();
    sx = 1'b1;
    f[2*IN_WIDTH +: IN_WIDTH] = 12'h9A5;
    held = model(32'h9A5, sx);
    push_frame(f, sx);
    bus.out_ready = 1'b0;
    send_frame(f, sx, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_ch", 64'(bus.out_ch), 64'd2);
      check("stall_out_last", 64'(bus.out_last), 64'd0);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_data", 64'(bus.out_data), 64'(held));
      @(posedge clk);
      #1;
      bus.in_data     = rand_frame();
      bus.in_sign_ext = $urandom_range(0, 1);
      bus.in_valid    = 1'b1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset after ch1 is accepted; the partial frame is dropped.
    f = rand_frame();
    push_frame(f, 1'b1);
    send_frame(f, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_ch", 64'(bus.out_ch), 64'd0);
    check("midrst_out_last", 64'(bus.out_last), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    g = rand_frame();
    push_frame(g, 1'b0);
    send_frame(g, 1'b0, 1'b0);
    drain();

    // Random frames, random sign mode, random gaps and random out_ready.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bit keep;
      f    = rand_frame();
      sx   = $urandom_range(0, 1);
      keep = (i != 29) && ($urandom_range(0, 1) == 1);
      push_frame(f, sx);
      send_frame(f, sx, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    drain();
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
